// File: rtl/bin2bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Digits use [0:3] ordering so bit 0 is the most significant bit of the nibble.
package bin2bcd_pkg;

    localparam int DIGITS = 8;
    localparam int BIN_W  = 27;

    typedef logic [0:3] digit_t;

    localparam logic [BIN_W-1:0] MAX_VAL    = 27'd99_999_999;
    localparam digit_t           BLANK_CODE = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble correction cell: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  digit_t d_i,
    output digit_t d_o
);

    assign d_o = (d_i >= 4'd5) ? digit_t'(d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle, results committed atomically.
// Optional leading-zero blanking when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int CYCLES = BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic [0:7]       point_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output digit_t           bcd8,
    output digit_t           bcd7,
    output digit_t           bcd6,
    output digit_t           bcd5,
    output digit_t           bcd4,
    output digit_t           bcd3,
    output digit_t           bcd2,
    output digit_t           bcd1,
    output logic [0:7]       point
);

    localparam int                SCR_W    = 4 * DIGITS;
    localparam int                CNT_W    = $clog2(CYCLES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CYCLES - 1);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [SCR_W-1:0]  RST_RES  = {{(DIGITS-1){BLANK_CODE}}, 4'h0};
`else
    localparam logic [SCR_W-1:0]  RST_RES  = '0;
`endif

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q;
    logic [SCR_W-1:0]     scr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [0:7]           pnt_lat_q;
    logic                 ovf_lat_q;
    logic [SCR_W-1:0]     res_q;
    logic [0:7]           point_q;
    logic                 ovf_q;
    logic                 done_q;

    logic                 accept;
    logic                 last;
    logic [BIN_W-1:0]     clamped;
    logic [SCR_W-1:0]     adj;
    logic [SCR_W+BIN_W-1:0] shift_all;
    logic [SCR_W-1:0]     final_scr;
    logic [SCR_W-1:0]     committed;

    assign accept  = (state_q == ST_IDLE) && start;
    assign last    = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign clamped = (bin > MAX_VAL) ? MAX_VAL : bin;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
        dabble_digit u_dabble (
            .d_i (scr_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    // The scratch MSB shifts out here; the clamp keeps it zero.
    assign shift_all = {adj, bin_q} << 1;
    assign final_scr = shift_all[SCR_W+BIN_W-1 -: SCR_W];

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        logic lead;
        committed = final_scr;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (final_scr[4*i +: 4] == 4'd0);
            if (lead) begin
                committed[4*i +: 4] = BLANK_CODE;
            end
        end
    end
`else
    assign committed = final_scr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_SHIFT);
        done  = done_q;
        ovf   = ovf_q;
        point = point_q;
        bcd8  = res_q[31:28];
        bcd7  = res_q[27:24];
        bcd6  = res_q[23:20];
        bcd5  = res_q[19:16];
        bcd4  = res_q[15:12];
        bcd3  = res_q[11:8];
        bcd2  = res_q[7:4];
        bcd1  = res_q[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            pnt_lat_q <= '1;
            ovf_lat_q <= 1'b0;
            res_q     <= RST_RES;
            point_q   <= '1;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                bin_q     <= clamped;
                scr_q     <= '0;
                cnt_q     <= '0;
                pnt_lat_q <= point_in;
                ovf_lat_q <= (bin > MAX_VAL);
            end else if (state_q == ST_SHIFT) begin
                {scr_q, bin_q} <= shift_all;
                cnt_q          <= cnt_q + 1'b1;
                if (last) begin
                    res_q   <= committed;
                    point_q <= pnt_lat_q;
                    ovf_q   <= ovf_lat_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: decimal reference model plus directed literal checks.
module tb_bin2bcd_seq;

    localparam int unsigned MAXV = 99_999_999;
`ifdef BIN2BCD_BLANK_EN
    localparam logic [31:0] RST_DIG = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] RST_DIG = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst, start;
    logic [26:0] bin;
    logic [0:7]  point_in;
    logic        busy, done, ovf;
    logic [0:3]  bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1;
    logic [0:7]  point;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned done_cnt   = 0;
    bit          chk_en     = 1'b0;

    // model state
    int          m_rem = 0;
    logic [31:0] m_dig = RST_DIG, p_dig = '0;
    logic [0:7]  m_point = '1, p_point = '1;
    logic        m_ovf = 1'b0, p_ovf = 1'b0, m_done = 1'b0, m_busy = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .point_in(point_in),
        .busy(busy), .done(done), .ovf(ovf),
        .bcd8(bcd8), .bcd7(bcd7), .bcd6(bcd6), .bcd5(bcd5),
        .bcd4(bcd4), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1),
        .point(point)
    );

    function automatic logic [31:0] golden(input logic [26:0] v);
        int unsigned x;
        logic [31:0] r;
        x = (int'(v) > MAXV) ? MAXV : int'(v);
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        for (int i = 7; i > 0; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic logic [31:0] dut_dig();
        return {bcd8, bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_rem = 0; m_dig = RST_DIG; m_point = '1; m_ovf = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_dig = p_dig; m_point = p_point; m_ovf = p_ovf; m_done = 1'b1;
                end
            end else if (start) begin
                m_rem   = 27;
                p_dig   = golden(bin);
                p_point = point_in;
                p_ovf   = int'(bin) > MAXV;
            end
        end
        m_busy = (m_rem != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            vectors++;
            if ({busy, done, ovf, dut_dig(), point} !== {m_busy, m_done, m_ovf, m_dig, m_point}) begin
                miscompares++;
                $display("FAIL model t=%0t: got busy=%b done=%b ovf=%b dig=%h pt=%h, expected busy=%b done=%b ovf=%b dig=%h pt=%h",
                         $time, busy, done, ovf, dut_dig(), point, m_busy, m_done, m_ovf, m_dig, m_point);
            end
        end
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic convert(input logic [26:0] v, input logic [0:7] p,
                           input logic [31:0] exp_dig, input logic exp_ovf, input string name);
        @(negedge clk);
        bin = v; point_in = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bin = 27'($urandom); point_in = 8'($urandom);
        wait_done(name);
        chk({name, "_dig"}, 64'(dut_dig()), 64'(exp_dig));
        chk({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        chk({name, "_pt"},  64'(point), 64'(p));
    endtask

    initial begin
        int unsigned d0;
        rst = 1'b1; start = 1'b0; bin = '0; point_in = '1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_dig", 64'(dut_dig()), 64'(RST_DIG));
        chk("reset_ctl", 64'({busy, done, ovf}), 64'd0);
        chk("reset_pt", 64'(point), 64'hFF);
        rst = 1'b0;

        // pin the model with hand-computed values
        chk("model_12345678", 64'(golden(27'd12_345_678)), 64'h1234_5678);
        chk("model_clamp", 64'(golden(27'd100_000_000)), 64'h9999_9999);

        convert(27'd12_345_678, 8'hFF, 32'h1234_5678, 1'b0, "c12345678");
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
`ifdef BIN2BCD_BLANK_EN
        convert(27'd0, 8'hFF, 32'hFFFF_FFF0, 1'b0, "c0");
        convert(27'd1005, 8'hFB, 32'hFFFF_1005, 1'b0, "c1005");
`else
        convert(27'd0, 8'hFF, 32'h0000_0000, 1'b0, "c0");
        convert(27'd1005, 8'hFB, 32'h0000_1005, 1'b0, "c1005");
`endif
        convert(27'd100_000_000, 8'h7E, 32'h9999_9999, 1'b1, "cmax");
`ifdef BIN2BCD_BLANK_EN
        convert(27'd42, 8'hFF, 32'hFFFF_FF42, 1'b0, "c42");
`else
        convert(27'd42, 8'hFF, 32'h0000_0042, 1'b0, "c42");
`endif

        // start during busy is ignored
        d0 = done_cnt;
        @(negedge clk); bin = 27'd555; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        bin = 27'd777; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("ign");
`ifdef BIN2BCD_BLANK_EN
        chk("ign_dig", 64'(dut_dig()), 64'hFFFF_F555);
`else
        chk("ign_dig", 64'(dut_dig()), 64'h0000_0555);
`endif
        repeat (30) @(negedge clk);
        chk("ign_done_cnt", 64'(done_cnt - d0), 64'd1);

        // reset in the middle of a conversion
        d0 = done_cnt;
        @(negedge clk); bin = 27'd12_345_678; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_dig", 64'(dut_dig()), 64'(RST_DIG));
        repeat (30) @(negedge clk);
        chk("rst_mid_nodone", 64'(done_cnt - d0), 64'd0);
        convert(27'd87_654_321, 8'hFF, 32'h8765_4321, 1'b0, "after_rst");

        // start together with reset: reset wins
        @(negedge clk); rst = 1'b1; start = 1'b1; bin = 27'd5;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);

        // randomized traffic, including held start and occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: bin = 27'($urandom_range(0, 999));
                1: bin = 27'($urandom_range(99_999_990, 100_000_010));
                default: bin = 27'($urandom);
            endcase
            point_in = 8'($urandom);
            start = (n % 600 < 150) ? 1'b1 : ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
